countdown_timer: RTL and testbench

Countdown timer feeding the 4-digit seven-segment `display` block with a 13-bit value (0–4999). It counts down once per prescaled tick from a loadable start value, supports start, pause and resume, and flags expiry with a single-cycle `timeout` pulse that game/control logic consumes. The `value` output is registered and connects directly to `display.value`.

---
 rtl/countdown_timer.sv | 131 +++++++++++++
 tb/tb_countdown_timer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter for the seven-segment display.
// Decrements `value` once every CLKS_PER_TICK cycles while running, with
// start / pause / resume control and a one-cycle `timeout` pulse on expiry.
// Optional feature macro: COUNTDOWN_TIMER_AUTORELOAD_EN -- when defined, the
// counter reloads the last loaded value on expiry and keeps running.
//
// state | meaning
// IDLE  | stopped, waiting for start (value != 0)
// RUN   | prescaler advancing, value decrements on each tick
// PAUSE | prescaler and value frozen, waiting for start
// DONE  | expired, value held at 0 until load or reset
module countdown_timer #(
  parameter int CLKS_PER_TICK = 50_000_000,
  parameter int MAX_VALUE     = 4999,
  parameter int START_VALUE   = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        load,
  input  logic [12:0] load_value,
  output logic [12:0] value,
  output logic        running,
  output logic        timeout
);

  localparam int VW = 13;
  localparam int PW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [VW-1:0]  value_d;
  logic           running_d, timeout_d;
  logic [VW-1:0]  load_sat;
  logic           tick;
  logic           expire;
  logic           start_ok;
  logic [VW-1:0]  expire_value;

  assign load_sat = (load_value > VW'(MAX_VALUE)) ? VW'(MAX_VALUE) : load_value;
  assign tick     = (state_q == RUN) && (presc_q == PW'(CLKS_PER_TICK - 1));
  assign expire   = tick && (value == VW'(1));

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [VW-1:0] reload_q;

  // Reload register remembers the most recent applied load value
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       reload_q <= VW'(START_VALUE);
    else if (load) reload_q <= load_sat;
  end

  assign start_ok     = (reload_q != '0);
  assign expire_value = reload_q;
`else
  assign start_ok     = (value != '0);
  assign expire_value = '0;
`endif

  // State and registered outputs; reset forces outputs without a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      value   <= VW'(START_VALUE);
      running <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      value   <= value_d;
      running <= running_d;
      timeout <= timeout_d;
    end
  end

  // Next-state decode; load overrides every state
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start && start_ok) state_d = RUN;
        RUN: begin
          if (pause) state_d = PAUSE;
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (expire) state_d = DONE;
`endif
        end
        PAUSE: if (start) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Next values for prescaler, count and output flags
  always_comb begin
    presc_d   = presc_q;
    value_d   = value;
    running_d = (state_d == RUN);
    timeout_d = 1'b0;
    if (load) begin
      value_d = load_sat;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: if (state_d == RUN) presc_d = '0;
        RUN: begin
          if (tick) begin
            // a tick due in the same cycle as pause still decrements
            presc_d = '0;
            if (expire) begin
              value_d   = expire_value;
              timeout_d = 1'b1;
            end else begin
              value_d = value - 1'b1;
            end
          end else if (!pause) begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: presc_d = presc_q;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CLKS_PER_TICK=4, START_VALUE=3.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        load = 1'b0;
  logic [12:0] load_value = '0;
  logic [12:0] value;
  logic        running;
  logic        timeout;

  int compared = 0;
  int mismatched = 0;

  countdown_timer #(
    .CLKS_PER_TICK(4),
    .MAX_VALUE    (4999),
    .START_VALUE  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .load      (load),
    .load_value(load_value),
    .value     (value),
    .running   (running),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic        pa;
    logic [12:0] lv;
    int          exp_value;
    logic        exp_running;
    logic        exp_timeout;
  } vec_t;

  vec_t vecs[24];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic ld, input logic st, input logic pa,
                         input int lv, input int ev, input logic er, input logic et);
    vecs[i].ld = ld;
    vecs[i].st = st;
    vecs[i].pa = pa;
    vecs[i].lv = 13'(lv);
    vecs[i].exp_value = ev;
    vecs[i].exp_running = er;
    vecs[i].exp_timeout = et;
  endtask

  initial begin
    int cyc;
    bit seen;

    // load, start, pause, load_value -> value, running, timeout (after the edge)
    set_vec(0,  1, 0, 0, 6000, 4999, 0, 0);
    set_vec(1,  1, 0, 0, 0,    0,    0, 0);
    set_vec(2,  0, 1, 0, 0,    0,    0, 0);
    set_vec(3,  0, 1, 0, 0,    0,    0, 0);
    set_vec(4,  1, 0, 0, 7,    7,    0, 0);
    set_vec(5,  0, 0, 1, 0,    7,    0, 0);
    set_vec(6,  1, 1, 0, 2,    2,    0, 0);
    set_vec(7,  0, 1, 0, 0,    2,    1, 0);
    set_vec(8,  0, 0, 0, 0,    2,    1, 0);
    set_vec(9,  0, 1, 0, 0,    2,    1, 0);
    set_vec(10, 0, 0, 0, 0,    2,    1, 0);
    set_vec(11, 0, 0, 0, 0,    1,    1, 0);
    set_vec(12, 0, 0, 0, 0,    1,    1, 0);
    set_vec(13, 0, 0, 1, 0,    1,    0, 0);
    set_vec(14, 0, 0, 0, 0,    1,    0, 0);
    set_vec(15, 0, 0, 1, 0,    1,    0, 0);
    set_vec(16, 0, 1, 0, 0,    1,    1, 0);
    set_vec(17, 0, 0, 0, 0,    1,    1, 0);
    set_vec(18, 0, 0, 0, 0,    1,    1, 0);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    set_vec(19, 0, 0, 0, 0,    2,    1, 1);
    set_vec(20, 0, 0, 0, 0,    2,    1, 0);
    set_vec(21, 0, 1, 0, 0,    2,    1, 0);
`else
    set_vec(19, 0, 0, 0, 0,    0,    0, 1);
    set_vec(20, 0, 0, 0, 0,    0,    0, 0);
    set_vec(21, 0, 1, 0, 0,    0,    0, 0);
`endif
    set_vec(22, 1, 0, 0, 4999, 4999, 0, 0);
    set_vec(23, 1, 0, 0, 5000, 4999, 0, 0);

    // reset state and idle hold
    step();
    rst = 1'b0;
    check("reset_value", int'(value), 3);
    check("reset_running", int'(running), 0);
    check("reset_timeout", int'(timeout), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle_hold_%0d", i), int'(value), 3);
    end

    // table vectors
    for (int i = 0; i < 24; i++) begin
      load = vecs[i].ld;
      start = vecs[i].st;
      pause = vecs[i].pa;
      load_value = vecs[i].lv;
      step();
      check($sformatf("vec%0d_value", i), int'(value), vecs[i].exp_value);
      check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_running));
      check($sformatf("vec%0d_timeout", i), int'(timeout), int'(vecs[i].exp_timeout));
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;

    // full run from 1438
    load = 1'b1; load_value = 13'd1438; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 6000 && !seen) begin
      step();
      cyc++;
      if (cyc == 4) check("full_first_dec", int'(value), 1437);
      if (timeout) seen = 1'b1;
    end
    check("full_timeout_cycle", cyc, 5752);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    check("full_reload_value", int'(value), 1438);
    check("full_still_running", int'(running), 1);
`else
    check("full_end_value", int'(value), 0);
    check("full_end_running", int'(running), 0);
    step();
    check("full_timeout_single", int'(timeout), 0);
    start = 1'b1; step(); start = 1'b0;
    check("done_start_value", int'(value), 0);
    check("done_start_running", int'(running), 0);
    step();
    check("done_no_timeout", int'(timeout), 0);
`endif

    // pause 2 cycles into a tick, hold, resume
    load = 1'b1; load_value = 13'd5; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    step();
    pause = 1'b1; step(); pause = 1'b0;
    check("pause_running", int'(running), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("pause_hold_%0d", i), int'(value), 5);
    end
    start = 1'b1; step(); start = 1'b0;
    check("resume_running", int'(running), 1);
    step();
    check("resume_edge1", int'(value), 5);
    step();
    check("resume_edge2", int'(value), 4);

    // asynchronous reset mid-run
    load = 1'b1; load_value = 13'd3; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_value", int'(value), 2);
    step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_value", int'(value), 3);
    check("async_rst_running", int'(running), 0);
    #2 rst = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("post_reset_dec", int'(value), 2);
    check("post_reset_running", int'(running), 1);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    // autoreload period
    load = 1'b1; load_value = 13'd2; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      cyc = 0;
      seen = 1'b0;
      while (cyc < 20 && !seen) begin
        step();
        cyc++;
        if (timeout) seen = 1'b1;
      end
      check($sformatf("autoreload_period_%0d", r), cyc, 8);
      check($sformatf("autoreload_value_%0d", r), int'(value), 2);
      check($sformatf("autoreload_running_%0d", r), int'(running), 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
